// File: rtl/id_ex_stage_reg_pkg.sv
// Shared widths, ALU codes, control bundle and update-priority selection for the ID/EX stage.
package id_ex_stage_reg_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_ALU_OP_W   = 4;
    localparam int DEF_CNT_W      = 16;

    localparam logic [3:0] ALU_OP_ADD    = 4'd0;
    localparam logic [3:0] ALU_OP_SUB    = 4'd1;
    localparam logic [3:0] ALU_OP_AND    = 4'd2;
    localparam logic [3:0] ALU_OP_OR     = 4'd3;
    localparam logic [3:0] ALU_OP_SLT    = 4'd4;
    localparam logic [3:0] ALU_OP_BUBBLE = 4'd0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_FLUSH,
        UPD_STALL,
        UPD_CAPTURE
    } upd_sel_e;

    // Hold beats flush beats stall; anything else captures the ID instruction.
    function automatic upd_sel_e update_sel(input logic hold, input logic flush, input logic stall);
        if (hold)  return UPD_HOLD;
        if (flush) return UPD_FLUSH;
        if (stall) return UPD_STALL;
        return UPD_CAPTURE;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX stage register.
interface id_ex_stage_reg_if #(
    parameter int DATA_W     = id_ex_stage_reg_pkg::DEF_DATA_W,
    parameter int REG_ADDR_W = id_ex_stage_reg_pkg::DEF_REG_ADDR_W,
    parameter int ALU_OP_W   = id_ex_stage_reg_pkg::DEF_ALU_OP_W,
    parameter int CNT_W      = id_ex_stage_reg_pkg::DEF_CNT_W
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_instr_rs;
    logic [REG_ADDR_W-1:0] id_instr_rt;
    logic [REG_ADDR_W-1:0] id_instr_rd;
    logic                  id_uses_rt;
    logic [DATA_W-1:0]     id_read_data1;
    logic [DATA_W-1:0]     id_read_data2;
    logic [DATA_W-1:0]     id_imm;
    logic [DATA_W-1:0]     id_pc_plus4;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_mem_to_reg;
    logic                  id_alu_src;
    logic                  id_reg_dst;
    logic [ALU_OP_W-1:0]   id_alu_op;
    logic                  ex_flush;
    logic                  ex_hold;

    logic                  id_ex_valid;
    logic [REG_ADDR_W-1:0] id_ex_instr_rs;
    logic [REG_ADDR_W-1:0] id_ex_instr_rt;
    logic [REG_ADDR_W-1:0] id_ex_write_reg_addr;
    logic [DATA_W-1:0]     id_ex_read_data1;
    logic [DATA_W-1:0]     id_ex_read_data2;
    logic [DATA_W-1:0]     id_ex_imm;
    logic [DATA_W-1:0]     id_ex_pc_plus4;
    logic                  id_ex_reg_write;
    logic                  id_ex_mem_read;
    logic                  id_ex_mem_write;
    logic                  id_ex_mem_to_reg;
    logic                  id_ex_alu_src;
    logic [ALU_OP_W-1:0]   id_ex_alu_op;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  load_use_stall;
    logic [CNT_W-1:0]      bubble_count;

    modport master (
        output id_valid, id_instr_rs, id_instr_rt, id_instr_rd, id_uses_rt,
               id_read_data1, id_read_data2, id_imm, id_pc_plus4,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
               id_alu_op, ex_flush, ex_hold,
        input  id_ex_valid, id_ex_instr_rs, id_ex_instr_rt, id_ex_write_reg_addr,
               id_ex_read_data1, id_ex_read_data2, id_ex_imm, id_ex_pc_plus4,
               id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src,
               id_ex_alu_op, pc_write, if_id_write, load_use_stall, bubble_count
    );

    modport slave (
        input  id_valid, id_instr_rs, id_instr_rt, id_instr_rd, id_uses_rt,
               id_read_data1, id_read_data2, id_imm, id_pc_plus4,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
               id_alu_op, ex_flush, ex_hold,
        output id_ex_valid, id_ex_instr_rs, id_ex_instr_rt, id_ex_write_reg_addr,
               id_ex_read_data1, id_ex_read_data2, id_ex_imm, id_ex_pc_plus4,
               id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src,
               id_ex_alu_op, pc_write, if_id_write, load_use_stall, bubble_count
    );

endinterface

// File: rtl/id_ex_stage_reg_load_use_hazard_detect.sv
// Load-use hazard detect: a load in EX whose nonzero rt is a source of the ID instruction.
// Latency: purely combinational.
// Backpressure: none; the parent turns the hazard into a stall.
module id_ex_stage_reg_load_use_hazard_detect
    import id_ex_stage_reg_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    output logic                  hz_o
);
    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    // $0 is hardwired, so a load targeting it can never create a real dependency.
    assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rt_i != REG_ADDR_W'(REG_ZERO));
    assign rs_match   = (ex_rt_i == id_rs_i);
    assign rt_match   = id_uses_rt_i & (ex_rt_i == id_rt_i);
    assign hz_o       = ex_is_load & id_valid_i & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall, branch flush, downstream hold and bubble counter.
// Latency: 1 cycle ID->EX; a load-use hazard costs exactly one bubble.
// Backpressure: ex_hold freezes every register; pc_write/if_id_write drop on hold or stall.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int ALU_OP_W   = DEF_ALU_OP_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_reg_if.slave bus
);
    logic     hz;
    logic     stall;
    upd_sel_e sel;
    ctrl_t    id_ctrl;

    logic                  valid_q,  valid_d;
    logic [REG_ADDR_W-1:0] rs_q,     rs_d;
    logic [REG_ADDR_W-1:0] rt_q,     rt_d;
    logic [REG_ADDR_W-1:0] wr_q,     wr_d;
    logic [DATA_W-1:0]     rd1_q,    rd1_d;
    logic [DATA_W-1:0]     rd2_q,    rd2_d;
    logic [DATA_W-1:0]     imm_q,    imm_d;
    logic [DATA_W-1:0]     pc4_q,    pc4_d;
    ctrl_t                 ctrl_q,   ctrl_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;

    id_ex_stage_reg_load_use_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_hazard_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rt_i       (rt_q),
        .id_valid_i    (bus.id_valid),
        .id_rs_i       (bus.id_instr_rs),
        .id_rt_i       (bus.id_instr_rt),
        .id_uses_rt_i  (bus.id_uses_rt),
        .hz_o          (hz)
    );

    // A taken branch squashes the dependent instruction, so there is nothing left to stall.
    assign stall              = hz & ~bus.ex_flush;
    assign bus.load_use_stall = stall;
    assign bus.pc_write       = ~(bus.ex_hold | stall);
    assign bus.if_id_write    = ~(bus.ex_hold | stall);
    assign sel                = update_sel(bus.ex_hold, bus.ex_flush, stall);

    assign id_ctrl = '{
        reg_write:  bus.id_reg_write,
        mem_read:   bus.id_mem_read,
        mem_write:  bus.id_mem_write,
        mem_to_reg: bus.id_mem_to_reg,
        alu_src:    bus.id_alu_src
    };

    always_comb begin
        valid_d  = valid_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        wr_d     = wr_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        pc4_d    = pc4_q;
        ctrl_d   = ctrl_q;
        alu_op_d = alu_op_q;
        cnt_d    = cnt_q;
        case (sel)
            UPD_HOLD: begin
            end
            UPD_FLUSH, UPD_STALL: begin
                // Zeroed addresses keep the forwarding unit from ever matching a bubble.
                valid_d  = 1'b0;
                rs_d     = REG_ADDR_W'(REG_ZERO);
                rt_d     = REG_ADDR_W'(REG_ZERO);
                wr_d     = REG_ADDR_W'(REG_ZERO);
                rd1_d    = '0;
                rd2_d    = '0;
                imm_d    = '0;
                pc4_d    = '0;
                ctrl_d   = CTRL_BUBBLE;
                alu_op_d = ALU_OP_W'(ALU_OP_BUBBLE);
                if ((sel == UPD_STALL) && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                valid_d  = bus.id_valid;
                rs_d     = bus.id_valid ? bus.id_instr_rs : REG_ADDR_W'(REG_ZERO);
                rt_d     = bus.id_valid ? bus.id_instr_rt : REG_ADDR_W'(REG_ZERO);
                wr_d     = !bus.id_valid ? REG_ADDR_W'(REG_ZERO)
                         : (bus.id_reg_dst ? bus.id_instr_rd : bus.id_instr_rt);
                rd1_d    = bus.id_read_data1;
                rd2_d    = bus.id_read_data2;
                imm_d    = bus.id_imm;
                pc4_d    = bus.id_pc_plus4;
                ctrl_d   = bus.id_valid ? id_ctrl : CTRL_BUBBLE;
                alu_op_d = bus.id_valid ? bus.id_alu_op : ALU_OP_W'(ALU_OP_BUBBLE);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            wr_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            pc4_q    <= '0;
            ctrl_q   <= CTRL_BUBBLE;
            alu_op_q <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            wr_q     <= wr_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            pc4_q    <= pc4_d;
            ctrl_q   <= ctrl_d;
            alu_op_q <= alu_op_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.id_ex_valid          = valid_q;
    assign bus.id_ex_instr_rs       = rs_q;
    assign bus.id_ex_instr_rt       = rt_q;
    assign bus.id_ex_write_reg_addr = wr_q;
    assign bus.id_ex_read_data1     = rd1_q;
    assign bus.id_ex_read_data2     = rd2_q;
    assign bus.id_ex_imm            = imm_q;
    assign bus.id_ex_pc_plus4       = pc4_q;
    assign bus.id_ex_reg_write      = ctrl_q.reg_write;
    assign bus.id_ex_mem_read       = ctrl_q.mem_read;
    assign bus.id_ex_mem_write      = ctrl_q.mem_write;
    assign bus.id_ex_mem_to_reg     = ctrl_q.mem_to_reg;
    assign bus.id_ex_alu_src        = ctrl_q.alu_src;
    assign bus.id_ex_alu_op         = alu_op_q;
    assign bus.bubble_count         = cnt_q;

endmodule
